// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the filter mode controller: mode/FSM enums,
// control-word encodings and command byte values.
package filter_ctrl_pkg;

    // Enum order matches the low two bits of the command bytes 0x30..0x33.
    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_IDLE = 2'd1,
        MODE_IIR  = 2'd2,
        MODE_FIR  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF,
        S_IDLE,
        S_IIR,
        S_FIR,
        S_FLUSH,
        S_SETTLE
    } fsm_e;

    localparam logic [2:0] CW_OFF  = 3'b000;
    localparam logic [2:0] CW_IDLE = 3'b001;
    localparam logic [2:0] CW_FIR  = 3'b011;
    localparam logic [2:0] CW_IIR  = 3'b111;

    localparam logic [7:0] CMD_OFF  = 8'h30;
    localparam logic [7:0] CMD_IDLE = 8'h31;
    localparam logic [7:0] CMD_IIR  = 8'h32;
    localparam logic [7:0] CMD_FIR  = 8'h33;

    function automatic logic [2:0] mode_word(input mode_e m);
        case (m)
            MODE_IDLE: return CW_IDLE;
            MODE_IIR:  return CW_IIR;
            MODE_FIR:  return CW_FIR;
            default:   return CW_OFF;
        endcase
    endfunction

    function automatic fsm_e stable_state(input mode_e m);
        case (m)
            MODE_IDLE: return S_IDLE;
            MODE_IIR:  return S_IIR;
            MODE_FIR:  return S_FIR;
            default:   return S_OFF;
        endcase
    endfunction

endpackage

// File: rtl/filter_settle_timer.sv
// Flush/settle down-counter: load wins over decrement, clear wins over load.
// Latency: expire_o is high for the last counted cycle. No backpressure.
module filter_settle_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       expire_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == 8'd1);

endmodule

// File: rtl/filter_mode_ctrl.sv
// Filter mode controller; state_o changes on the accepting edge, busy for SETTLE_CYCLES (2x for IIR<->FIR).
// cmd_ready_o drops while flushing/settling or while off_i is high; FILTER_MODE_CTRL_ERR_CNT_EN adds err_cnt_o.
module filter_mode_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    input  logic       off_i,
    output logic [2:0] state_o,
    output logic       busy_o,
    output logic       err_o,
    output logic [7:0] err_cnt_o
);

    fsm_e       fsm_q, fsm_d;
    mode_e      mode_q, mode_d;
    mode_e      target_q, target_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic       err_q, err_d;
    logic       tmr_load, tmr_clear, tmr_expire;
    logic       stable, accept, cmd_known, iir_fir_swap;
    mode_e      cmd_mode;

    assign stable       = (fsm_q != S_FLUSH) && (fsm_q != S_SETTLE);
    assign cmd_ready_o  = stable && !off_i;
    assign accept       = cmd_valid_i && cmd_ready_o;
    assign cmd_known    = (cmd_data_i >= CMD_OFF) && (cmd_data_i <= CMD_FIR);
    assign cmd_mode     = mode_e'(cmd_data_i[1:0]);
    assign iir_fir_swap = ((mode_q == MODE_IIR) && (cmd_mode == MODE_FIR)) ||
                          ((mode_q == MODE_FIR) && (cmd_mode == MODE_IIR));

    always_comb begin
        fsm_d     = fsm_q;
        mode_d    = mode_q;
        target_d  = target_q;
        ctrl_d    = ctrl_q;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        if (off_i) begin
            fsm_d     = S_OFF;
            mode_d    = MODE_OFF;
            ctrl_d    = CW_OFF;
            tmr_clear = 1'b1;
        end else begin
            case (fsm_q)
                S_FLUSH: begin
                    if (tmr_expire) begin
                        mode_d   = target_q;
                        ctrl_d   = mode_word(target_q);
                        fsm_d    = S_SETTLE;
                        tmr_load = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (tmr_expire) begin
                        fsm_d = stable_state(mode_q);
                    end
                end
                default: begin
                    if (accept) begin
                        if (!cmd_known) begin
                            err_d = 1'b1;
                        end else if (cmd_mode != mode_q) begin
                            tmr_load = 1'b1;
                            // Swapping filter types passes through IDLE so no mixed coefficients are seen.
                            if (iir_fir_swap) begin
                                fsm_d    = S_FLUSH;
                                ctrl_d   = CW_IDLE;
                                target_d = cmd_mode;
                            end else begin
                                fsm_d  = S_SETTLE;
                                mode_d = cmd_mode;
                                ctrl_d = mode_word(cmd_mode);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q    <= S_OFF;
            mode_q   <= MODE_OFF;
            target_q <= MODE_OFF;
            ctrl_q   <= CW_OFF;
            err_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            ctrl_q   <= ctrl_d;
            err_q    <= err_d;
        end
    end

    filter_settle_timer u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (8'(SETTLE_CYCLES)),
        .expire_o   (tmr_expire)
    );

`ifdef FILTER_MODE_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 8'd0;
`endif

    assign state_o = ctrl_q;
    assign busy_o  = !stable;
    assign err_o   = err_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Bench for filter_mode_ctrl with SETTLE_CYCLES=4: directed scenarios plus random
// command/off traffic, all compared against a cycle-count reference model.
module tb_filter_mode_ctrl;

    localparam int N = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cmd_valid_i;
    logic [7:0] cmd_data_i;
    logic       cmd_ready_o;
    logic       off_i;
    logic [2:0] state_o;
    logic       busy_o;
    logic       err_o;
    logic [7:0] err_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: expected control word, cycles of busy left, and the
    // busy-left value at which a pending IIR<->FIR target becomes visible.
    logic [2:0] m_word;
    logic [2:0] m_target;
    int         m_busy_left;
    int         m_switch_at;
    logic       m_err;
    int         m_cnt;

    filter_mode_ctrl #(.SETTLE_CYCLES(N)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_ready_o (cmd_ready_o),
        .off_i       (off_i),
        .state_o     (state_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [2:0] word_of(input logic [7:0] d);
        case (d)
            8'h31:   return 3'b001;
            8'h32:   return 3'b111;
            8'h33:   return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] exp_cnt();
`ifdef FILTER_MODE_CTRL_ERR_CNT_EN
        return 8'(m_cnt);
`else
        return 8'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_word = 3'b000; m_target = 3'b000; m_busy_left = 0;
        m_switch_at = -1; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic o);
        logic [2:0] tw;
        m_err = 1'b0;
        if (o) begin
            m_word = 3'b000; m_busy_left = 0; m_switch_at = -1;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == m_switch_at) begin
                m_word = m_target; m_switch_at = -1;
            end
        end else if (v) begin
            if (d >= 8'h30 && d <= 8'h33) begin
                tw = word_of(d);
                if (tw != m_word) begin
                    if ((m_word == 3'b111 && tw == 3'b011) || (m_word == 3'b011 && tw == 3'b111)) begin
                        m_busy_left = 2 * N; m_switch_at = N; m_target = tw; m_word = 3'b001;
                    end else begin
                        m_busy_left = N; m_word = tw;
                    end
                end
            end else begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    endtask

    // Called at posedge+1: drive, compare every output, clock, advance model.
    task automatic step(input logic v, input logic [7:0] d, input logic o);
        cmd_valid_i = v; cmd_data_i = d; off_i = o;
        #1;
        check("state_o", {5'b0, state_o}, {5'b0, m_word});
        check("busy_o", {7'b0, busy_o}, {7'b0, m_busy_left > 0});
        check("err_o", {7'b0, err_o}, {7'b0, m_err});
        check("err_cnt_o", err_cnt_o, exp_cnt());
        check("cmd_ready_o", {7'b0, cmd_ready_o}, {7'b0, (m_busy_left == 0) && !o});
        @(posedge clk_i);
        model_edge(v, d, o);
        #1;
    endtask

    task automatic run_idle(output int nbusy);
        int k;
        nbusy = 0;
        k = 0;
        while (cmd_ready_o !== 1'b1 && k < 50) begin
            if (busy_o === 1'b1) nbusy++;
            step(1'b0, 8'h00, 1'b0);
            k++;
        end
        check("ready_after_busy", {7'b0, cmd_ready_o}, 8'd1);
    endtask

    initial begin
        int nb;
        int r;
        logic [7:0] d;
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_data_i = 8'h00; off_i = 1'b0;
        model_reset();
        #12;
        check("rst_state", {5'b0, state_o}, 8'h00);
        check("rst_busy", {7'b0, busy_o}, 8'h00);
        check("rst_err", {7'b0, err_o}, 8'h00);
        check("rst_cnt", err_cnt_o, 8'h00);
        check("rst_ready", {7'b0, cmd_ready_o}, 8'h01);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // OFF -> IDLE: word on next edge, 4 busy cycles, ready afterwards.
        step(1'b1, 8'h31, 1'b0);
        check("idle_word", {5'b0, state_o}, 8'h01);
        run_idle(nb);
        check("settle_len", 8'(nb), 8'd4);

        // IDLE -> IIR -> FIR (flush through IDLE).
        step(1'b1, 8'h32, 1'b0);
        check("iir_word", {5'b0, state_o}, 8'h07);
        run_idle(nb);
        step(1'b1, 8'h33, 1'b0);
        check("flush_word", {5'b0, state_o}, 8'h01);
        run_idle(nb);
        check("flush_settle_len", 8'(nb), 8'd8);
        check("fir_word", {5'b0, state_o}, 8'h03);

        // Back to IIR, then same-mode command is a no-op.
        step(1'b1, 8'h32, 1'b0);
        run_idle(nb);
        step(1'b1, 8'h32, 1'b0);
        check("same_busy", {7'b0, busy_o}, 8'h00);
        check("same_ready", {7'b0, cmd_ready_o}, 8'h01);
        check("same_word", {5'b0, state_o}, 8'h07);

        // Unknown byte.
        step(1'b1, 8'h41, 1'b0);
        check("bad_err", {7'b0, err_o}, 8'h01);
`ifdef FILTER_MODE_CTRL_ERR_CNT_EN
        check("bad_cnt", err_cnt_o, 8'h01);
`else
        check("bad_cnt", err_cnt_o, 8'h00);
`endif
        step(1'b0, 8'h00, 1'b0);
        check("bad_err_pulse", {7'b0, err_o}, 8'h00);
        for (int i = 0; i < 300; i++) step(1'b1, 8'h41, 1'b0);
        step(1'b0, 8'h00, 1'b0);
`ifdef FILTER_MODE_CTRL_ERR_CNT_EN
        check("cnt_saturate", err_cnt_o, 8'hFF);
`else
        check("cnt_saturate", err_cnt_o, 8'h00);
`endif

        // off_i during second flush cycle.
        step(1'b1, 8'h33, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("off_word", {5'b0, state_o}, 8'h00);
        check("off_busy", {7'b0, busy_o}, 8'h00);
        step(1'b1, 8'h33, 1'b0);
        check("after_off_fir", {5'b0, state_o}, 8'h03);
        step(1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-settle.
        cmd_valid_i = 1'b0; off_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("arst_word", {5'b0, state_o}, 8'h00);
        check("arst_busy", {7'b0, busy_o}, 8'h00);
        check("arst_cnt", err_cnt_o, 8'h00);
        check("arst_ready", {7'b0, cmd_ready_o}, 8'h01);
        model_reset();
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        step(1'b1, 8'h32, 1'b0);
        check("resume_iir", {5'b0, state_o}, 8'h07);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8) d = 8'h30 + 8'(r % 4);
            else d = 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 1)), d, ($urandom_range(0, 29) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_mode_ctrl.md
FILTER_MODE_CTRL -- requirements
Module: filter_mode_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning the number of cycles the command port stays blocked after each mode change; legal range 1..255.
REQ-002 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid_i  input  1  command byte valid.
REQ-005 SHALL have port cmd_data_i  input  8  command byte: 0x30 OFF, 0x31 IDLE, 0x32 IIR, 0x33 FIR.
REQ-006 SHALL have port cmd_ready_o  output  1  command byte accepted when high together with cmd_valid_i.
REQ-007 SHALL have port off_i  input  1  synchronous force-OFF, highest priority.
REQ-008 SHALL have port state_o  output  3  filter control word: OFF=3'b000, IDLE=3'b001, FIR=3'b011, IIR=3'b111 (bit0 enable, bit1 filter, bit2 IIR select).
REQ-009 SHALL have port busy_o  output  1  high while flushing or settling.
REQ-010 SHALL have port err_o  output  1  one-cycle pulse on accepted unknown byte.
REQ-011 SHALL have port err_cnt_o  output  8  saturating count of unknown bytes.

Function
REQ-012 SHALL use FSM states S_OFF, S_IDLE, S_IIR, S_FIR (stable) and S_FLUSH, S_SETTLE (busy).
REQ-013 SHALL drive cmd_ready_o high exactly when in a stable state and off_i is low.
REQ-014 SHALL accept a byte on a rising edge where cmd_valid_i and cmd_ready_o are both high.
REQ-015 SHALL update state_o from registers on the edge that accepts a command; no combinational path from cmd_* to state_o.
REQ-016 SHALL leave state_o unchanged, with busy_o low, when an accepted command targets the current mode.
REQ-017 SHALL, on an accepted change not between IIR and FIR, set state_o to the target, then enter S_SETTLE for SETTLE_CYCLES cycles with busy_o high.
REQ-018 SHALL, on an accepted IIR<->FIR change, drive state_o=IDLE in S_FLUSH for SETTLE_CYCLES cycles, then set state_o to the target and enter S_SETTLE for SETTLE_CYCLES cycles.
REQ-019 SHALL return to the stable state matching state_o when the S_SETTLE count expires, raising cmd_ready_o on the following cycle.
REQ-020 SHALL, on an accepted byte outside 0x30..0x33, pulse err_o for one cycle, leave state_o unchanged, and stay stable.
REQ-021 SHALL, when off_i is high at any edge (including in S_FLUSH or S_SETTLE), set state_o=OFF, clear the settle counter, and go to S_OFF with busy_o low; no byte is accepted that cycle.
REQ-022 SHALL treat an OFF command like any other change (REQ-017), including settling.

Reset
REQ-023 SHALL, on rst_ni low, asynchronously force S_OFF, state_o=3'b000, busy_o=0, err_o=0, err_cnt_o=0, counter=0, cmd_ready_o=1 (if off_i low).
REQ-024 SHALL abandon any flush or settle in progress when reset is asserted mid-operation; no pending target is retained.

Configuration
REQ-025 SHALL use macro FILTER_MODE_CTRL_ERR_CNT_EN: when defined, err_cnt_o increments on each err_o pulse and saturates at 255; when undefined, err_cnt_o is constant 0 with no counter flops, and err_o is unaffected.

Structure
REQ-026 SHALL place the mode enum, 3-bit control-word encodings and command byte constants in package filter_ctrl_pkg.
REQ-027 SHALL implement the flush/settle down-counter as sub-module filter_settle_timer (load, decrement, expire pulse), used once.

Verification
All scenarios use SETTLE_CYCLES=4.
REQ-028 SHALL cover reset release then 0x31 -> state_o=001 on the next edge; busy_o high for 4 cycles; cmd_ready_o high on cycle 6.
REQ-029 SHALL cover IDLE, then 0x32, then 0x33 after settling -> state_o=111, then 001 for 4 cycles, then 011; busy_o high for 8 cycles total.
REQ-030 SHALL cover 0x32 while in IIR -> state_o stays 111, busy_o stays 0, cmd_ready_o stays 1.
REQ-031 SHALL cover byte 0x41 -> err_o pulses once and err_cnt_o goes 0->1 (macro defined) or stays 0 (undefined); 300 bad bytes -> err_cnt_o=255.
REQ-032 SHALL cover off_i pulsed during the second S_FLUSH cycle -> state_o=000 on the next edge, busy_o=0, and the next 0x33 accepted normally.
REQ-033 SHALL cover rst_ni low during S_SETTLE from 0x33 -> state_o=000 immediately (no clock), err_cnt_o=0, FSM resumes from S_OFF.
